// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake and data-memory port bundle for mem_access_ctrl.
//   req_*  : datapath request (valid/ready), store byte, word address
//   rsp_*  : load result / error back to the datapath (valid/ready)
//   mem_*  : data memory port (combinational read, synchronous byte write)
// slave modport is the controller side; master is the datapath + memory side.
interface mem_access_ctrl_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [7:0]        req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_write;
   logic [7:0]        mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  rsp_ready, mem_data_out,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_address, mem_write, mem_data_in
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output rsp_ready, mem_data_out,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_address, mem_write, mem_data_in
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the processor datapath and a 64 x 16 data memory.
// One request at a time: accept, check, sequence one READ or WRITE cycle, then
// hold the response until the datapath takes it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_access_ctrl_if.slave (request, response and memory port)
module mem_access_ctrl #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MEM_DEPTH = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_access_ctrl_if.slave    bus
);

   localparam logic [1:0] SIZE_LO   = 2'b00;
   localparam logic [1:0] SIZE_HI   = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              mem_write_q, mem_write_d;

   logic              accept_c;
   logic              req_bad_c;

   // Byte select plus optional sign extension of a loaded word.
   function automatic logic [DATA_W-1:0] format_load(input logic [DATA_W-1:0] word,
                                                      input logic [1:0]        size,
                                                      input logic              sgn);
      logic [7:0] byte_v;
      logic       ext;
      byte_v = (size == SIZE_HI) ? word[15:8] : word[7:0];
      ext    = sgn & byte_v[7];
      if (size == SIZE_WORD) return word;
      return {{(DATA_W-8){ext}}, byte_v};
   endfunction

   assign accept_c  = bus.req_valid && req_ready_q;

   // Rejected at accept time: out of range, reserved size, or non-byte store.
   assign req_bad_c = (32'(bus.req_addr) >= MEM_DEPTH) ||
                      (bus.req_size == SIZE_RSVD) ||
                      (bus.req_we && (bus.req_size != SIZE_LO));

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 8'h00;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         mem_write_q <= mem_write_d;
      end
   end

   // Next state and next values of the registered outputs.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      signed_d    = signed_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mem_write_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept_c) begin
               we_d     = bus.req_we;
               size_d   = bus.req_size;
               signed_d = bus.req_signed;
               addr_d   = bus.req_addr;
               wdata_d  = bus.req_wdata;
               if (req_bad_c) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else if (bus.req_we) begin
                  state_d     = WRITE;
                  mem_write_d = 1'b1;
               end else begin
                  state_d     = READ;
               end
            end
         end
         READ: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = we_q ? '0 : format_load(bus.mem_data_out, size_q, signed_q);
         end
         WRITE: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = '0;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase

      req_ready_d = (state_d == IDLE);
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_write   = mem_write_q;
   assign bus.mem_data_in = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized
// loads/stores checked against an array-based model of the data memory.
module tb_mem_access_ctrl;

   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned MEM_DEPTH = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [15:0] mem     [MEM_DEPTH];
   logic [15:0] ref_mem [MEM_DEPTH];
   int unsigned wr_total;
   int          n_checks = 0;
   int          n_errors = 0;

   function automatic logic [15:0] init_word(input int i);
      if (i == 9) return 16'h80F0;
      return 16'((i * 32'h1357) ^ 32'hA5C3);
   endfunction

   // Data memory: combinational read, low byte written on the clock edge.
   assign bus.mem_data_out = (32'(bus.mem_address) < MEM_DEPTH) ?
                             mem[bus.mem_address[5:0]] : 16'hDEAD;

   initial begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] = init_word(i);
      wr_total = 0;
      forever begin
         @(posedge clk);
         if (bus.mem_write === 1'b1) begin
            wr_total++;
            if (32'(bus.mem_address) < MEM_DEPTH)
               mem[bus.mem_address[5:0]][7:0] = bus.mem_data_in;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive_junk();
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'($urandom);
      bus.req_size   = 2'($urandom);
      bus.req_signed = 1'($urandom);
      bus.req_addr   = 8'($urandom);
      bus.req_wdata  = 8'($urandom);
   endtask

   // One full transaction; called and returns on a negative clock edge.
   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [7:0] addr, input logic [7:0] wdata,
                         input int hold, input bit junk, output logic [15:0] rd);
      logic        err;
      logic [15:0] exp_rd;
      logic [15:0] w;
      logic [7:0]  b;
      int unsigned wr0;
      int          lat;

      err    = (addr >= 8'(MEM_DEPTH)) || (size == 2'd3) || (we && size != 2'd0);
      exp_rd = 16'h0000;
      if (!err && !we) begin
         w = ref_mem[addr[5:0]];
         if (size == 2'd2) exp_rd = w;
         else begin
            b = (size == 2'd0) ? w[7:0] : w[15:8];
            exp_rd = (sgn && b >= 8'd128) ? 16'hFF00 + 16'(b) : 16'(b);
         end
      end

      check("req_ready_idle", 32'(bus.req_ready), 32'd1);
      wr0 = wr_total;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.req_addr   = 8'($urandom);
      bus.req_wdata  = 8'($urandom);
      check("req_ready_busy", 32'(bus.req_ready), 32'd0);
      if (!err && we) begin
         check("write_strobe", 32'(bus.mem_write), 32'd1);
         check("write_addr", 32'(bus.mem_address), 32'(addr));
         check("write_data", 32'(bus.mem_data_in), 32'(wdata));
      end

      lat = 1;
      while (bus.rsp_valid !== 1'b1 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check("rsp_latency", 32'(lat), err ? 32'd1 : 32'd2);
      check("rsp_err", 32'(bus.rsp_err), 32'(err));
      check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
      rd = bus.rsp_rdata;
      if (!err && we) ref_mem[addr[5:0]][7:0] = wdata;

      for (int i = 0; i < hold; i++) begin
         if (junk) drive_junk();
         @(posedge clk);
         @(negedge clk);
         check("hold_valid", 32'(bus.rsp_valid), 32'd1);
         check("hold_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
         check("hold_err", 32'(bus.rsp_err), 32'(err));
         check("hold_ready", 32'(bus.req_ready), 32'd0);
      end

      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("rsp_done_valid", 32'(bus.rsp_valid), 32'd0);
      check("rsp_done_ready", 32'(bus.req_ready), 32'd1);
      check("write_count", 32'(wr_total - wr0), (!err && we) ? 32'd1 : 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd;
      int unsigned wr0;

      for (int i = 0; i < int'(MEM_DEPTH); i++) ref_mem[i] = init_word(i);
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = 8'h00;
      bus.req_wdata  = 8'h00;
      bus.rsp_ready  = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_mem_write", 32'(bus.mem_write), 32'd0);
      check("rst_mem_address", 32'(bus.mem_address), 32'd0);
      check("rst_mem_data_in", 32'(bus.mem_data_in), 32'd0);
      check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
      check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Byte store then word load of the same address
      do_req(1'b1, 2'd0, 1'b0, 8'd5, 8'hA5, 0, 1'b0, rd);
      do_req(1'b0, 2'd2, 1'b0, 8'd5, 8'h00, 0, 1'b0, rd);
      check("store_then_load_lo", 32'(rd[7:0]), 32'hA5);

      // Byte select and sign extension on 16'h80F0
      do_req(1'b0, 2'd1, 1'b1, 8'd9, 8'h00, 0, 1'b0, rd);
      check("hi_signed", 32'(rd), 32'hFF80);
      do_req(1'b0, 2'd1, 1'b0, 8'd9, 8'h00, 0, 1'b0, rd);
      check("hi_unsigned", 32'(rd), 32'h0080);
      do_req(1'b0, 2'd0, 1'b1, 8'd9, 8'h00, 0, 1'b0, rd);
      check("lo_signed", 32'(rd), 32'hFFF0);
      do_req(1'b0, 2'd2, 1'b1, 8'd9, 8'h00, 0, 1'b0, rd);
      check("word", 32'(rd), 32'h80F0);

      // Rejected accesses
      do_req(1'b0, 2'd2, 1'b0, 8'd64, 8'h00, 0, 1'b0, rd);
      do_req(1'b1, 2'd2, 1'b0, 8'd7, 8'h3C, 0, 1'b0, rd);
      do_req(1'b0, 2'd3, 1'b0, 8'd3, 8'h00, 1, 1'b0, rd);
      do_req(1'b1, 2'd0, 1'b0, 8'd255, 8'h11, 0, 1'b0, rd);

      // Response back-pressure with stray requests, then a follow-up request
      do_req(1'b0, 2'd0, 1'b1, 8'd9, 8'h00, 4, 1'b1, rd);
      do_req(1'b1, 2'd0, 1'b0, 8'd20, 8'h5A, 4, 1'b1, rd);
      do_req(1'b0, 2'd2, 1'b0, 8'd20, 8'h00, 0, 1'b0, rd);

      // Reset pulsed during the WRITE cycle
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = 8'd12;
      bus.req_wdata  = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("rstw_strobe", 32'(bus.mem_write), 32'd1);
      wr0 = wr_total;
      #2 rst_n = 1'b0;
      #1;
      check("rstw_write_drop", 32'(bus.mem_write), 32'd0);
      check("rstw_req_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("rstw_no_rsp", 32'(bus.rsp_valid), 32'd0);
         @(negedge clk);
      end
      check("rstw_no_write", 32'(wr_total - wr0), 32'd0);
      do_req(1'b0, 2'd2, 1'b0, 8'd12, 8'h00, 0, 1'b0, rd);

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
         do_req(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                2'($urandom), 1'($urandom),
                8'($urandom_range(0, 79)), 8'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom), rd);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
